// File: rtl/core_bus_arb_pkg.sv
// rtl/core_bus_arb_pkg.sv - shared types and arbitration pick for the core memory-port arbiter
package core_bus_arb_pkg;

  // Transaction phase of the single memory-port slot.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Which requester owns the in-flight transaction.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Fetches go out as plain word reads (read_type LW).
  localparam logic [2:0] TYPE_FETCH = 3'b010;

  // Data is the older instruction and normally wins; fetch wins only once it
  // has been passed over the maximum number of times while waiting.
  function automatic owner_e arb_pick(input logic if_req,
                                      input logic d_req,
                                      input logic starved);
    if (d_req && !(starved && if_req)) begin
      return OWN_D;
    end
    return OWN_IF;
  endfunction

endpackage

// File: rtl/core_bus_arb.sv
// rtl/core_bus_arb.sv - shares one memory port between instruction fetch and data access
module core_bus_arb
  import core_bus_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  input  logic               if_flush_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [INSTR_W-1:0] if_rdata_o,
  input  logic               d_req_i,
  input  logic               d_we_i,
  input  logic [2:0]         d_type_i,
  input  logic [ADDR_W-1:0]  d_addr_i,
  input  logic [DATA_W-1:0]  d_wdata_i,
  output logic               d_gnt_o,
  output logic               d_rvalid_o,
  output logic [DATA_W-1:0]  d_rdata_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [2:0]         bus_type_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic [DATA_W-1:0]  bus_wdata_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [DATA_W-1:0]  bus_rdata_i,
  output logic               stall_o
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  state_e           state;
  owner_e           owner;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;

  logic   rsp_fire;
  logic   arb_en;
  logic   any_req;
  logic   starved;
  logic   flush_hit;
  logic   drop_now;
  owner_e win;

  // A response only counts once the bus has accepted the command.
  assign rsp_fire  = bus_rvalid_i && (state == ST_RSP);
  // The slot frees up in IDLE or in the very cycle the response lands.
  assign arb_en    = (state == ST_IDLE) || rsp_fire;
  assign any_req   = if_req_i || d_req_i;
  assign starved   = (starve_cnt == CNT_W'(STARVE_LIM));
  assign win       = arb_pick(if_req_i, d_req_i, starved);

  // A redirect kills an in-flight fetch; a redirect in the response cycle
  // itself already makes that response stale.
  assign flush_hit = if_flush_i && (owner == OWN_IF) && (state != ST_IDLE);
  assign drop_now  = drop || flush_hit;

  assign if_gnt_o    = arb_en && any_req && (win == OWN_IF);
  assign d_gnt_o     = arb_en && any_req && (win == OWN_D);
  assign if_rvalid_o = rsp_fire && (owner == OWN_IF) && !drop_now;
  assign d_rvalid_o  = rsp_fire && (owner == OWN_D);
  assign if_rdata_o  = bus_rdata_i[INSTR_W-1:0];
  assign d_rdata_o   = bus_rdata_i;

  // Hold the pipeline while any requester has not yet seen its data.
  assign stall_o = (d_req_i && !d_rvalid_o) || (if_req_i && !if_rvalid_o);

  // Transaction FSM: latch the winner's command, hold bus_req until accepted, await the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_IF;
      drop        <= 1'b0;
      starve_cnt  <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_type_o  <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      if (arb_en && any_req) begin
        state     <= ST_REQ;
        bus_req_o <= 1'b1;
        owner     <= win;
        drop      <= 1'b0;
        if (win == OWN_D) begin
          bus_we_o    <= d_we_i;
          bus_type_o  <= d_type_i;
          bus_addr_o  <= d_addr_i;
          bus_wdata_o <= d_wdata_i;
          if (if_req_i && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end else begin
          bus_we_o    <= 1'b0;
          bus_type_o  <= TYPE_FETCH;
          bus_addr_o  <= if_addr_i;
          bus_wdata_o <= '0;
          starve_cnt  <= '0;
        end
      end else if (rsp_fire) begin
        state <= ST_IDLE;
        drop  <= 1'b0;
      end else begin
        if ((state == ST_REQ) && bus_gnt_i) begin
          state     <= ST_RSP;
          bus_req_o <= 1'b0;
        end
        if (flush_hit) begin
          drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_bus_arb.sv
// tb/tb_core_bus_arb.sv - scoreboard bench for core_bus_arb
module tb_core_bus_arb;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
  logic [2:0]  d_type = '0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, bus_req_o, bus_we_o, stall_o;
  logic [31:0] if_rdata_o;
  logic [63:0] d_rdata_o, bus_addr_o, bus_wdata_o;
  logic [2:0]  bus_type_o;

  always #5 clk = ~clk;

  core_bus_arb #(.ADDR_W(64), .DATA_W(64), .INSTR_W(32), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_type_i(d_type), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_type_o(bus_type_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .stall_o(stall_o)
  );

  typedef struct { int cyc; bit is_d; } gnt_t;
  typedef struct { int cyc; bit is_d; logic [63:0] data; } rsp_t;
  typedef struct { bit is_d; bit we; logic [2:0] typ; logic [63:0] addr; logic [63:0] wdata; } cmd_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  cmd_t cmd_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one transaction slot (0 free, 1 waiting for bus accept, 2 waiting for data)
  int m_phase = 0, n_phase = 0;
  bit m_own_d = 0, n_own_d = 0, m_drop = 0, n_drop = 0;
  int m_starve = 0, n_starve = 0;
  bit if_won = 0, d_won = 0;
  bit exp_stall = 0, exp_bus_req = 0;

  int unsigned pct_if = 0, pct_d = 0, pct_gnt = 0, pct_rv = 0, pct_flush = 0, pct_spur = 0;
  bit fix_rdata_en = 0, fix_if_en = 0;
  logic [63:0] fix_rdata = '0, fix_if_addr = '0;

  bit chk_starve = 0;
  int dg_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the model's prediction for that clock
  task automatic step();
    bit resp, arb, win_d, drop_now, exp_if_rv, exp_d_rv;
    @(posedge clk); #1;
    m_phase = n_phase; m_own_d = n_own_d; m_drop = n_drop; m_starve = n_starve;
    if (if_won) if_req = 1'b0;
    if (d_won) d_req = 1'b0;
    if (!if_req && $urandom_range(99) < pct_if) begin
      if_req  = 1'b1;
      if_addr = fix_if_en ? fix_if_addr : ({$urandom, $urandom} & ~64'h3);
    end
    if (!d_req && $urandom_range(99) < pct_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_type  = d_we ? {1'b0, 2'($urandom_range(3))} : 3'($urandom_range(6));
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
    end
    bus_gnt    = (m_phase == 1) && ($urandom_range(99) < pct_gnt);
    bus_rvalid = (m_phase == 2) && ($urandom_range(99) < pct_rv);
    if (m_phase != 2 && $urandom_range(99) < pct_spur) bus_rvalid = 1'b1;
    bus_rdata  = fix_rdata_en ? fix_rdata : {$urandom, $urandom};
    if_flush   = ($urandom_range(99) < pct_flush);

    n_phase = m_phase; n_own_d = m_own_d; n_drop = m_drop; n_starve = m_starve;
    if_won = 0; d_won = 0; exp_if_rv = 0; exp_d_rv = 0;
    resp = (m_phase == 2) && bus_rvalid;
    arb  = (m_phase == 0) || resp;
    drop_now = m_drop || (if_flush && m_phase != 0 && !m_own_d);
    if (resp) begin
      if (m_own_d) begin
        exp_d_rv = 1;
        rsp_q.push_back('{cyc, 1'b1, bus_rdata});
      end else if (!drop_now) begin
        exp_if_rv = 1;
        rsp_q.push_back('{cyc, 1'b0, {32'h0, bus_rdata[31:0]}});
      end
      n_phase = 0; n_drop = 0;
    end else begin
      if (m_phase == 1 && bus_gnt) n_phase = 2;
      if (m_phase != 0 && !m_own_d && if_flush) n_drop = 1;
    end
    if (arb && (if_req || d_req)) begin
      win_d = d_req && !(if_req && m_starve >= LIM);
      if (win_d) begin
        d_won = 1;
        cmd_q.push_back('{1'b1, d_we, d_type, d_addr, d_wdata});
        if (if_req) n_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      end else begin
        if_won = 1;
        cmd_q.push_back('{1'b0, 1'b0, 3'b000, if_addr, 64'h0});
        n_starve = 0;
      end
      gnt_q.push_back('{cyc, win_d});
      n_phase = 1; n_own_d = win_d; n_drop = 0;
    end
    exp_bus_req = (m_phase == 1);
    exp_stall   = (d_req && !exp_d_rv) || (if_req && !exp_if_rv);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    if_req = 0; d_req = 0; if_flush = 0; d_we = 0; bus_gnt = 0; bus_rvalid = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_type = '0; bus_rdata = '0;
    m_phase = 0; n_phase = 0; m_own_d = 0; n_own_d = 0; m_drop = 0; n_drop = 0;
    m_starve = 0; n_starve = 0; if_won = 0; d_won = 0;
    exp_stall = 0; exp_bus_req = 0;
    cmd_q.delete();
    #2;
    check("rst_ctrl", 64'({bus_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, stall_o, bus_we_o}), 64'h0);
    check("rst_bus_addr", bus_addr_o, 64'h0);
    check("rst_bus_wdata", bus_wdata_o, 64'h0);
    check("rst_bus_type", 64'(bus_type_o), 64'h0);
    check("rst_rdata", d_rdata_o | 64'(if_rdata_o), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  gnt_t g;
  rsp_t r;
  cmd_t c;

  // Monitor: pops expectations whenever the DUT presents a grant, response or bus accept
  always @(negedge clk) begin
    while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
      g = gnt_q.pop_front();
      check("gnt_missing", 64'(cyc), 64'(g.cyc));
    end
    while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
      r = rsp_q.pop_front();
      check("rvalid_missing", 64'(cyc), 64'(r.cyc));
    end
    if (if_gnt_o || d_gnt_o) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", 64'({if_gnt_o, d_gnt_o}), 64'h0);
      else begin
        g = gnt_q.pop_front();
        check("gnt_cycle", 64'(cyc), 64'(g.cyc));
        check("gnt_who", 64'({if_gnt_o, d_gnt_o}), g.is_d ? 64'h1 : 64'h2);
      end
      if (d_gnt_o) dg_run++;
      if (if_gnt_o) begin
        if (chk_starve) begin
          check("starve_data_grants", 64'(dg_run), 64'(LIM));
          chk_starve = 0;
        end
        dg_run = 0;
      end
    end
    if (if_rvalid_o || d_rvalid_o) begin
      if (rsp_q.size() == 0) check("rvalid_unexpected", 64'({if_rvalid_o, d_rvalid_o}), 64'h0);
      else begin
        r = rsp_q.pop_front();
        check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
        check("rvalid_who", 64'({if_rvalid_o, d_rvalid_o}), r.is_d ? 64'h1 : 64'h2);
        check("rdata", r.is_d ? d_rdata_o : {32'h0, if_rdata_o}, r.data);
      end
    end
    if (bus_req_o && bus_gnt) begin
      if (cmd_q.size() == 0) check("bus_cmd_unexpected", 64'(cmd_q.size()), 64'h1);
      else begin
        c = cmd_q.pop_front();
        check("bus_addr", bus_addr_o, c.addr);
        check("bus_we", 64'(bus_we_o), 64'(c.we));
        if (c.is_d) begin
          check("bus_type", 64'(bus_type_o), 64'(c.typ));
          check("bus_wdata", bus_wdata_o, c.wdata);
        end
      end
    end
    check("bus_req", 64'(bus_req_o), 64'(exp_bus_req));
    check("stall", 64'(stall_o), 64'(exp_stall));
  end

  initial begin
    // Reset, then idle with no requests
    do_reset();
    steps(4);

    // Lone fetch at 0x80 with a fixed instruction word, bus answers as fast as allowed
    pct_gnt = 100; pct_rv = 100;
    fix_if_en = 1; fix_if_addr = 64'h80; fix_rdata_en = 1; fix_rdata = 64'h00500093;
    pct_if = 100; step();
    pct_if = 0; steps(5);
    fix_if_en = 0; fix_rdata_en = 0;

    // Fetch and load in the same cycle: load first, fetch back-to-back on its response
    do_reset();
    pct_if = 100; pct_d = 100; step();
    pct_if = 0; pct_d = 0; steps(8);

    // Data held continuously against a waiting fetch: fetch after exactly LIM data grants
    do_reset();
    chk_starve = 1; dg_run = 0;
    pct_if = 100; pct_d = 100; steps(20);
    check("starve_fetch_seen", 64'(chk_starve), 64'h0);
    pct_if = 0; pct_d = 0; steps(6);

    // Redirect while the fetch waits for bus accept; fetcher keeps requesting
    do_reset();
    pct_gnt = 0; pct_rv = 100; pct_if = 100; step();
    steps(2);
    pct_flush = 100; step();
    pct_flush = 0; pct_gnt = 100; steps(4);
    pct_if = 0; steps(6);

    // Reset while waiting for data; later stray responses must be ignored
    do_reset();
    pct_rv = 0; pct_d = 100; step();
    pct_d = 0; steps(3);
    do_reset();
    pct_spur = 100; pct_rv = 100; steps(4);
    pct_spur = 0;

    // Randomized traffic with redirects, stray responses and random bus delays
    do_reset();
    pct_if = 40; pct_d = 40; pct_gnt = 60; pct_rv = 50; pct_flush = 10; pct_spur = 15;
    steps(2000);
    pct_if = 0; pct_d = 0; pct_flush = 0; pct_spur = 0; pct_gnt = 100; pct_rv = 100;
    steps(12);

    @(negedge clk); #1;
    check("gnt_q_drained", 64'(gnt_q.size()), 64'h0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'h0);
    check("cmd_q_drained", 64'(cmd_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
